hub75e_rx: RTL and testbench
============================

// Module: hub75e_rx
// PURPOSE
//  Receive end of the HUB75E panel interface: a synthesizable panel model. Samples the
//  CK/ST/OE/RGB/row pins driven by the panel scanner and rebuilds each latched row in a
//  line buffer. On every ST it dumps that row into a pixel RAM write port, addressed {row,col}.
//  Serves as bench scoreboard source and loopback checker next to the SPI pixel path.
// PARAMETERS
//  COLS        64  pixels shifted per row (power of 2); CW = $clog2(COLS)
//  ROW_BITS    5   row address width (HUB75E E..A)
//  SYNC_STAGES 2   synchronizer depth on all hub_* inputs (>=2)
// PORTS
//  clk          in   1            system clock; each hub_ck high and low phase must last >=2 clk
//  resetn       in   1            asynchronous active-low reset
//  hub_ck       in   1            shift clock; data valid on rising edge
//  hub_st       in   1            latch strobe; rising edge commits the row
//  hub_oe       in   1            output enable, active low (display on when 0)
//  hub_lines    in   ROW_BITS     row address {E,D,C,B,A}
//  hub_rgb      in   6            {R2,G2,B2,R1,G1,B1}
//  wr_en        out  1            pixel RAM write strobe
//  wr_addr      out  ROW_BITS+CW  {row,col}
//  wr_data      out  6            pixel bits, same order as hub_rgb
//  frame_done   out  1            1-clk pulse after row 2**ROW_BITS-1 flush completes
//  err_len      out  1            sticky: ST seen with shift count != COLS
//  err_overrun  out  1            sticky: ST seen while a flush is still running
// BEHAVIOUR
//  - Reset: all outputs 0; sync chains, col_cnt, row_q, state cleared; buffers not reset.
//  - All hub_* inputs pass through SYNC_STAGES FFs, then a 1-FF edge detector.
//    ck_rise/st_rise asserts 1 clk, SYNC_STAGES+1 clk after the pin edge.
//  - Shift: on ck_rise, live[col_cnt] <= synced hub_rgb; col_cnt <= col_cnt+1, mod COLS.
//    A hub_ck pulse while hub_st is high is still shifted.
//  - Latch: on st_rise: shadow <= live (all COLS entries, single cycle); row_q <= synced hub_lines.
//    err_len <= err_len | (shift count since last ST != COLS); count and col_cnt reset to 0.
//    The shift count is tracked separately, saturating at COLS+1.
//  - ck_rise and st_rise in the same cycle: shift first, then latch the updated live buffer.
//    Count includes that pixel.
//  - FSM: IDLE -> FLUSH on st_rise.
//    FLUSH issues one write per clk, wr_en=1, wr_addr={row_q,fcol}, wr_data=shadow[fcol].
//    fcol runs 0..COLS-1; first write 1 clk after st_rise; wr_en high exactly COLS consecutive clk.
//    FLUSH -> IDLE after fcol==COLS-1.
//    frame_done pulses the clk after that last write when row_q == all-ones.
//  - st_rise during FLUSH: err_overrun <= 1; shadow/row_q reloaded; fcol restarts at 0.
//    Stays in FLUSH; the aborted row is partially written, no frame_done for it.
//  - Live shifting continues during FLUSH (double buffer); only shadow feeds wr_*.
//  - hub_oe does not gate capture.
//  - Async reset mid-FLUSH: wr_en drops immediately, no further writes.
//    Errors clear only on reset.
// CONFIGURATION
//  HUB75E_RX_OE_STAT_EN defined:
//    + ports oe_on_cycles (out, 16) and oe_valid (out, 1).
//    Counter counts clk with synced hub_oe==0, saturating at 16'hFFFF.
//    On st_rise: oe_on_cycles <= counter, oe_valid pulses 1 clk, counter restarts (that cycle counts).
//    Reset values 0.
//  Not defined: ports and counter absent; all other behaviour identical.
// TESTING
//  1 Pin-level stimulus, ck 4 clk high/4 low:
//    64 pixels rgb=col[5:0] on row 5, then ST
//    -> wr_en 64 consecutive clk; wr_addr 0x140..0x17F; wr_data=col; no errors.
//  2 Full frame, rows 0..31, 64 px each, rgb=row^col
//    -> 2048 writes match, frame_done exactly once after row 31 col 63; none earlier.
//  3 Row with 63 ck pulses then ST
//    -> err_len=1 and stays 1; 64 writes still occur (col 63 = stale live data).
//  4 Second ST 20 clk after first, 64 px shifted between
//    -> err_overrun=1; second row restarts at col 0, all 64 written; first row cols 0..~19 only.
//  5 ck and st rising on same clk as 64th pixel -> pixel 63 written, err_len=0.
//    Assert resetn low mid-FLUSH -> wr_en 0 same cycle, all outputs 0.
//  6 (HUB75E_RX_OE_STAT_EN) hub_oe low 100 clk between two STs
//    -> oe_on_cycles=100 with oe_valid pulse; build without macro compiles, ports absent.

Source files
------------

// File: rtl/hub75e_rx_if.sv
// hub75e_rx_if: HUB75E panel pin bundle (shift clock, latch, output enable,
// row address and the two RGB pixel triplets). The panel scanner drives it
// through the master modport; the receive model samples it through slave.
interface hub75e_rx_if #(
  parameter int ROW_BITS = 5
);
  logic                hub_ck;
  logic                hub_st;
  logic                hub_oe;
  logic [ROW_BITS-1:0] hub_lines;
  logic [5:0]          hub_rgb;

  modport master (
    output hub_ck,
    output hub_st,
    output hub_oe,
    output hub_lines,
    output hub_rgb
  );

  modport slave (
    input hub_ck,
    input hub_st,
    input hub_oe,
    input hub_lines,
    input hub_rgb
  );
endinterface

// File: rtl/hub75e_rx.sv
// hub75e_rx: receive end of a HUB75E panel link. Pins are synchronized,
// shift clock edges fill a live line buffer, and every latch strobe copies
// the live buffer into a shadow buffer that is streamed into a pixel RAM
// write port as {row,col}. Length and overrun errors are sticky.
// Optional feature: define HUB75E_RX_OE_STAT_EN to add the oe_on_cycles /
// oe_valid display-on-time statistic ports.
module hub75e_rx #(
  parameter int COLS        = 64,
  parameter int ROW_BITS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                               clk,
  input  logic                               resetn,
  hub75e_rx_if.slave                         hub,
  output logic                               wr_en,
  output logic [ROW_BITS+$clog2(COLS)-1:0]   wr_addr,
  output logic [5:0]                         wr_data,
  output logic                               frame_done,
  output logic                               err_len,
  output logic                               err_overrun
`ifdef HUB75E_RX_OE_STAT_EN
  ,
  output logic [15:0]                        oe_on_cycles,
  output logic                               oe_valid
`endif
);

  localparam int CW = $clog2(COLS);
  localparam int SW = ROW_BITS + 9;
  localparam logic [CW:0]   FULL_CNT = (CW+1)'(COLS);
  localparam logic [CW:0]   SAT_CNT  = (CW+1)'(COLS + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  // synchronizer chain, all pins travel together so they stay aligned
  logic [SYNC_STAGES-1:0][SW-1:0] sync_q, sync_d;
  logic [SW-1:0]                  pins;
  logic [SW-1:0]                  synced;
  logic                           ck_s, st_s, oe_s;
  logic [ROW_BITS-1:0]            lines_s;
  logic [5:0]                     rgb_s;

  // edge detection
  logic ck_prev_q, ck_prev_d;
  logic st_prev_q, st_prev_d;
  logic ck_rise, st_rise;

  // shift / latch / flush state
  logic [CW-1:0]       col_cnt_q, col_cnt_d;
  logic [CW:0]         shift_cnt_q, shift_cnt_d;
  logic [CW:0]         shift_cnt_inc;
  logic [ROW_BITS-1:0] row_q, row_d;
  state_t              state_q, state_d;
  logic [CW-1:0]       fcol_q, fcol_d;
  logic [CW-1:0]       fcol_nxt;

  // registered outputs
  logic                   wr_en_q, wr_en_d;
  logic [ROW_BITS+CW-1:0] wr_addr_q, wr_addr_d;
  logic [5:0]             wr_data_q, wr_data_d;
  logic                   frame_done_q, frame_done_d;
  logic                   err_len_q, err_len_d;
  logic                   err_overrun_q, err_overrun_d;

  // line buffers, deliberately left out of reset
  logic [5:0] live_q   [COLS];
  logic [5:0] live_d   [COLS];
  logic [5:0] shadow_q [COLS];
  logic [5:0] shadow_d [COLS];

  assign pins    = {hub.hub_ck, hub.hub_st, hub.hub_oe, hub.hub_lines, hub.hub_rgb};
  assign synced  = sync_q[SYNC_STAGES-1];
  assign ck_s    = synced[SW-1];
  assign st_s    = synced[SW-2];
  assign oe_s    = synced[SW-3];
  assign lines_s = synced[6 +: ROW_BITS];
  assign rgb_s   = synced[5:0];

  assign ck_rise  = ck_s & ~ck_prev_q;
  assign st_rise  = st_s & ~st_prev_q;
  assign fcol_nxt = fcol_q + 1'b1;

  // next value of the synchronizer chain and the edge detector history
  always_comb begin
    sync_d[0] = pins;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    ck_prev_d = ck_s;
    st_prev_d = st_s;
  end

  // live buffer takes the shifted pixel first so a coincident latch sees it
  always_comb begin
    live_d   = live_q;
    shadow_d = shadow_q;
    if (ck_rise) begin
      live_d[col_cnt_q] = rgb_s;
    end
    if (st_rise) begin
      shadow_d = live_d;
    end
  end

  // shift counting, latch handling and the flush sequencer
  always_comb begin
    col_cnt_d     = col_cnt_q;
    shift_cnt_inc = shift_cnt_q;
    row_d         = row_q;
    state_d       = state_q;
    fcol_d        = fcol_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    err_len_d     = err_len_q;
    err_overrun_d = err_overrun_q;

    if (ck_rise) begin
      col_cnt_d = col_cnt_q + 1'b1;
      if (shift_cnt_q != SAT_CNT) begin
        shift_cnt_inc = shift_cnt_q + 1'b1;
      end
    end
    shift_cnt_d = shift_cnt_inc;

    if (st_rise) begin
      err_len_d   = err_len_q | (shift_cnt_inc != FULL_CNT);
      shift_cnt_d = '0;
      col_cnt_d   = '0;
      row_d       = lines_s;
      if (state_q == FLUSH) begin
        err_overrun_d = 1'b1;
      end
      state_d   = FLUSH;
      fcol_d    = '0;
      wr_en_d   = 1'b1;
      wr_addr_d = {lines_s, {CW{1'b0}}};
      wr_data_d = live_d[0];
    end else if (state_q == FLUSH) begin
      if (fcol_q == LAST_COL) begin
        state_d      = IDLE;
        wr_en_d      = 1'b0;
        frame_done_d = &row_q;
      end else begin
        fcol_d    = fcol_nxt;
        wr_en_d   = 1'b1;
        wr_addr_d = {row_q, fcol_nxt};
        wr_data_d = shadow_q[fcol_nxt];
      end
    end
  end

  // control and output registers, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q        <= '0;
      ck_prev_q     <= 1'b0;
      st_prev_q     <= 1'b0;
      col_cnt_q     <= '0;
      shift_cnt_q   <= '0;
      row_q         <= '0;
      state_q       <= IDLE;
      fcol_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      err_len_q     <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      ck_prev_q     <= ck_prev_d;
      st_prev_q     <= st_prev_d;
      col_cnt_q     <= col_cnt_d;
      shift_cnt_q   <= shift_cnt_d;
      row_q         <= row_d;
      state_q       <= state_d;
      fcol_q        <= fcol_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      err_len_q     <= err_len_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  // line buffer storage, contents are don't-care until first written
  always_ff @(posedge clk) begin
    live_q   <= live_d;
    shadow_q <= shadow_d;
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_done  = frame_done_q;
  assign err_len     = err_len_q;
  assign err_overrun = err_overrun_q;

`ifdef HUB75E_RX_OE_STAT_EN
  logic [15:0] oe_cnt_q, oe_cnt_d;
  logic [15:0] oe_on_q, oe_on_d;
  logic        oe_valid_q, oe_valid_d;

  // display-on time between latches; the latch cycle opens the next window
  always_comb begin
    oe_cnt_d   = oe_cnt_q;
    oe_on_d    = oe_on_q;
    oe_valid_d = 1'b0;
    if (st_rise) begin
      oe_on_d    = oe_cnt_q;
      oe_valid_d = 1'b1;
      oe_cnt_d   = {15'b0, ~oe_s};
    end else if (!oe_s && (oe_cnt_q != 16'hFFFF)) begin
      oe_cnt_d = oe_cnt_q + 16'd1;
    end
  end

  // statistic registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oe_cnt_q   <= '0;
      oe_on_q    <= '0;
      oe_valid_q <= 1'b0;
    end else begin
      oe_cnt_q   <= oe_cnt_d;
      oe_on_q    <= oe_on_d;
      oe_valid_q <= oe_valid_d;
    end
  end

  assign oe_on_cycles = oe_on_q;
  assign oe_valid     = oe_valid_q;
`else
  logic oe_unused;
  assign oe_unused = oe_s;
`endif

endmodule

// File: tb/tb_hub75e_rx.sv
// tb_hub75e_rx: pin-level scanner driving hub75e_rx. Every latch pushes the
// expected {row,col}/pixel writes into a queue; an independent monitor pops
// and compares whenever wr_en is seen, and also polices frame_done.
module tb_hub75e_rx;

  localparam int COLS     = 64;
  localparam int ROW_BITS = 5;

  typedef struct packed {
    logic [10:0] addr;
    logic [5:0]  data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [5:0]  wr_data;
  logic        frame_done;
  logic        err_len;
  logic        err_overrun;
`ifdef HUB75E_RX_OE_STAT_EN
  logic [15:0] oe_on_cycles;
  logic        oe_valid;
`endif

  exp_t       sb_q[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         fd_seen = 0;
  logic [5:0] model_live [COLS];
  int         model_col = 0;

  hub75e_rx_if #(.ROW_BITS(ROW_BITS)) hub_bus ();

  hub75e_rx #(.COLS(COLS), .ROW_BITS(ROW_BITS), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .hub         (hub_bus),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .err_len     (err_len),
    .err_overrun (err_overrun)
`ifdef HUB75E_RX_OE_STAT_EN
    ,
    .oe_on_cycles(oe_on_cycles),
    .oe_valid    (oe_valid)
`endif
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one pixel: data set with ck low for 4 clk, then ck high for 4 clk
  task automatic applyStimulus(input logic [5:0] v);
    hub_bus.hub_rgb = v;
    hub_bus.hub_ck  = 1'b0;
    tick(4);
    hub_bus.hub_ck  = 1'b1;
    tick(4);
    model_live[model_col] = v;
    model_col = (model_col + 1) % COLS;
  endtask

  task automatic push_expected(input int row, input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      e.addr = 11'((row << 6) | c);
      e.data = model_live[c];
      e.last = (row == 31) && (c == COLS - 1) && (n == COLS);
      sb_q.push_back(e);
    end
  endtask

  task automatic latch_row(input int row);
    hub_bus.hub_ck    = 1'b0;
    hub_bus.hub_lines = 5'(row);
    tick(4);
    push_expected(row, COLS);
    hub_bus.hub_st = 1'b1;
    tick(4);
    hub_bus.hub_st = 1'b0;
    tick(4);
    model_col = 0;
  endtask

  // scoreboard monitor, sampling on the falling edge
  initial begin
    exp_t e;
    logic fd_expect;
    fd_expect = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        fd_expect = 1'b0;
      end else begin
        if (frame_done) fd_seen++;
        if (frame_done || fd_expect) checkOutput("frame_done", 32'(frame_done), 32'(fd_expect));
        fd_expect = 1'b0;
        if (wr_en) begin
          if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_write: got write addr 0x%0h, expected no write", wr_addr);
          end else begin
            e = sb_q.pop_front();
            checkOutput("wr_addr", 32'(wr_addr), 32'(e.addr));
            checkOutput("wr_data", 32'(wr_data), 32'(e.data));
            fd_expect = e.last;
          end
        end
      end
    end
  end

  // run-time bound
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    hub_bus.hub_ck    = 1'b0;
    hub_bus.hub_st    = 1'b0;
    hub_bus.hub_oe    = 1'b1;
    hub_bus.hub_lines = '0;
    hub_bus.hub_rgb   = '0;
    for (int c = 0; c < COLS; c++) model_live[c] = '0;

    // reset state
    tick(3);
    checkOutput("reset_wr_en", 32'(wr_en), 0);
    checkOutput("reset_wr_addr", 32'(wr_addr), 0);
    checkOutput("reset_frame_done", 32'(frame_done), 0);
    checkOutput("reset_err_len", 32'(err_len), 0);
    checkOutput("reset_err_overrun", 32'(err_overrun), 0);
    resetn = 1'b1;
    tick(2);

    // row 5, rgb = col
    for (int c = 0; c < COLS; c++) applyStimulus(6'(c));
    latch_row(5);
    tick(70);
    checkOutput("t1_err_len", 32'(err_len), 0);
    checkOutput("t1_err_overrun", 32'(err_overrun), 0);

    // full frame, rgb = row ^ col
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < COLS; c++) applyStimulus(6'(r ^ c));
      if (r == 31) checkOutput("t2_no_early_frame_done", 32'(fd_seen), 0);
      latch_row(r);
    end
    tick(80);
    checkOutput("t2_frame_done_count", 32'(fd_seen), 1);
    checkOutput("t2_err_len", 32'(err_len), 0);

    // 64th pixel clocked together with the latch strobe
    for (int c = 0; c < COLS - 1; c++) applyStimulus(6'(c + 7));
    hub_bus.hub_rgb   = 6'h15;
    hub_bus.hub_ck    = 1'b0;
    hub_bus.hub_lines = 5'd12;
    tick(4);
    model_live[COLS-1] = 6'h15;
    push_expected(12, COLS);
    hub_bus.hub_ck = 1'b1;
    hub_bus.hub_st = 1'b1;
    tick(4);
    hub_bus.hub_ck = 1'b0;
    hub_bus.hub_st = 1'b0;
    tick(4);
    model_col = 0;
    tick(70);
    checkOutput("t5_err_len", 32'(err_len), 0);

    // short row: 63 pulses, col 63 keeps the stale 6'h15
    for (int c = 0; c < COLS - 1; c++) applyStimulus(6'(63 - c));
    latch_row(3);
    tick(70);
    checkOutput("t3_err_len", 32'(err_len), 1);
    checkOutput("t3_err_overrun", 32'(err_overrun), 0);

    // second latch 20 clk after the first: row 7 cols 0..19, then row 9 in full
    for (int c = 0; c < COLS; c++) applyStimulus(6'(c ^ 6'h2A));
    hub_bus.hub_ck    = 1'b0;
    hub_bus.hub_lines = 5'd7;
    tick(4);
    push_expected(7, 20);
    hub_bus.hub_st = 1'b1;
    tick(4);
    hub_bus.hub_st = 1'b0;
    tick(16);
    hub_bus.hub_lines = 5'd9;
    push_expected(9, COLS);
    hub_bus.hub_st = 1'b1;
    tick(4);
    hub_bus.hub_st = 1'b0;
    model_col = 0;
    tick(80);
    checkOutput("t4_err_overrun", 32'(err_overrun), 1);
    checkOutput("t4_err_len_sticky", 32'(err_len), 1);
    checkOutput("t4_queue_drained", 32'(sb_q.size()), 0);
    checkOutput("t4_frame_done_count", 32'(fd_seen), 1);

    // asynchronous reset in the middle of a flush
    for (int c = 0; c < COLS; c++) applyStimulus(6'(c + 1));
    hub_bus.hub_ck    = 1'b0;
    hub_bus.hub_lines = 5'd2;
    tick(4);
    push_expected(2, COLS);
    hub_bus.hub_st = 1'b1;
    tick(4);
    hub_bus.hub_st = 1'b0;
    tick(6);
    checkOutput("t5_flush_active", 32'(wr_en), 1);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("t5_rst_wr_en", 32'(wr_en), 0);
    checkOutput("t5_rst_wr_addr", 32'(wr_addr), 0);
    checkOutput("t5_rst_wr_data", 32'(wr_data), 0);
    checkOutput("t5_rst_err_len", 32'(err_len), 0);
    checkOutput("t5_rst_err_overrun", 32'(err_overrun), 0);
    checkOutput("t5_rst_frame_done", 32'(frame_done), 0);
    sb_q.delete();
    model_col = 0;
    tick(3);
    resetn = 1'b1;
    tick(80);
    checkOutput("t5_post_rst_wr_en", 32'(wr_en), 0);

`ifdef HUB75E_RX_OE_STAT_EN
    // display on for 100 clk between two latches
    begin
      logic seen;
      hub_bus.hub_lines = 5'd0;
      push_expected(0, COLS);
      hub_bus.hub_st = 1'b1;
      tick(4);
      hub_bus.hub_st = 1'b0;
      tick(10);
      hub_bus.hub_oe = 1'b0;
      tick(100);
      hub_bus.hub_oe = 1'b1;
      tick(10);
      push_expected(0, COLS);
      hub_bus.hub_st = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (oe_valid) seen = 1'b1;
      end
      checkOutput("t6_oe_valid", 32'(seen), 1);
      checkOutput("t6_oe_on_cycles", 32'(oe_on_cycles), 100);
      tick(2);
      hub_bus.hub_st = 1'b0;
      tick(80);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
